// File: rtl/dac82002_pkg.sv
// Shared constants, FSM state type and frame builder for the DAC82002 serial transmitter.
package dac82002_pkg;

  localparam int FRAME_W  = 24;
  localparam int SAMPLE_W = 16;

  localparam logic [7:0] CMD_DAC_A = 8'h08;
  localparam logic [7:0] CMD_DAC_B = 8'h09;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } dac_state_t;

  function automatic logic [FRAME_W-1:0] build_frame(input logic chan,
                                                      input logic [SAMPLE_W-1:0] code);
    return {(chan ? CMD_DAC_B : CMD_DAC_A), code};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO holding {chan, code} entries; the write side stays closed until the first edge after reset.
module sample_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_wr_valid,
  output logic         o_wr_ready,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_rd,
  output logic [W-1:0] o_rd_data,
  output logic         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_en;

  logic w_full;
  logic w_push;
  logic w_pop;

  // A full FIFO refuses writes even when a read frees a slot in the same cycle.
  assign w_full     = (r_cnt == CW'(DEPTH));
  assign o_empty    = (r_cnt == '0);
  assign o_wr_ready = r_en & ~w_full;
  assign w_push     = i_wr_valid & o_wr_ready;
  assign w_pop      = i_rd & ~o_empty;
  assign o_rd_data  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_en     <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_en <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/dac_spi_tx.sv
// DAC82002 24-bit serial frame transmitter fed by a sample FIFO.
// Define DAC_SPI_TX_OFFSET_BIN_EN to send samples as offset binary (MSB inverted).
module dac_spi_tx
  import dac82002_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                mck_i,
  input  logic                rst_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic                s_chan_i,
  input  logic [SAMPLE_W-1:0] s_data_i,
  output logic                sclk_o,
  output logic                sync_o,
  output logic                sdo_o,
  output logic                busy_o,
  output logic                frame_done_o,
  output dac_state_t          dbg_state_o
);

  localparam logic [7:0] DIV_LAST      = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_TAIL_LAST = (CLK_DIV > 1) ? 8'(CLK_DIV - 2) : 8'd0;
  localparam bit         GAP_ONE_HALF  = (CLK_DIV == 1);
  localparam logic [4:0] BIT_LAST      = 5'd23;

  dac_state_t           r_state;
  logic [FRAME_W-1:0]   r_frame;
  logic [4:0]           r_bit;
  logic [7:0]           r_div;
  logic                 r_sclk;
  logic                 r_sync;
  logic                 r_sdo;
  logic                 r_done;

  logic [SAMPLE_W-1:0]  w_code;
  logic [SAMPLE_W:0]    w_rd_data;
  logic                 w_empty;
  logic                 w_pop;

`ifdef DAC_SPI_TX_OFFSET_BIN_EN
  assign w_code = {~s_data_i[SAMPLE_W-1], s_data_i[SAMPLE_W-2:0]};
`else
  assign w_code = s_data_i;
`endif

  assign w_pop = (r_state == ST_IDLE) && !w_empty;

  sample_fifo #(
    .W     (SAMPLE_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (mck_i),
    .i_rst_n    (rst_i),
    .i_wr_valid (s_valid_i),
    .o_wr_ready (s_ready_o),
    .i_wr_data  ({s_chan_i, w_code}),
    .i_rd       (w_pop),
    .o_rd_data  (w_rd_data),
    .o_empty    (w_empty)
  );

  always_ff @(posedge mck_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_frame <= '0;
      r_bit   <= '0;
      r_div   <= '0;
      r_sclk  <= 1'b1;
      r_sync  <= 1'b1;
      r_sdo   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_frame <= build_frame(w_rd_data[SAMPLE_W], w_rd_data[SAMPLE_W-1:0]);
            r_bit   <= '0;
            r_div   <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // sync still high marks the first SHIFT cycle: open the frame with bit 23.
          if (r_sync) begin
            r_sync  <= 1'b0;
            r_sclk  <= 1'b1;
            r_sdo   <= r_frame[FRAME_W-1];
            r_frame <= {r_frame[FRAME_W-2:0], 1'b0};
            r_div   <= '0;
          end else if (r_div != DIV_LAST) begin
            r_div <= r_div + 8'd1;
          end else begin
            r_div <= '0;
            if (r_sclk) begin
              r_sclk <= 1'b0;
            end else if (r_bit == BIT_LAST) begin
              r_sync  <= 1'b1;
              r_sclk  <= 1'b1;
              r_sdo   <= 1'b0;
              r_done  <= 1'b1;
              r_bit   <= '0;
              r_state <= ST_GAP;
            end else begin
              r_bit   <= r_bit + 5'd1;
              r_sclk  <= 1'b1;
              r_sdo   <= r_frame[FRAME_W-1];
              r_frame <= {r_frame[FRAME_W-2:0], 1'b0};
            end
          end
        end
        ST_GAP: begin
          // Two half-periods, the second one cycle short: the IDLE pop cycle completes the gap.
          if (r_div != (r_bit[0] ? GAP_TAIL_LAST : DIV_LAST)) begin
            r_div <= r_div + 8'd1;
          end else if (r_bit[0] || GAP_ONE_HALF) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_div <= '0;
            r_bit <= 5'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sclk_o       = r_sclk;
  assign sync_o       = r_sync;
  assign sdo_o        = r_sdo;
  assign frame_done_o = r_done;
  assign busy_o       = (r_state != ST_IDLE);
  assign dbg_state_o  = r_state;

endmodule

// File: doc/dac_spi_tx.md
DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 Parameter CLK_DIV, default 2, SCLK half-period in mck_i cycles; legal range 1..255.
REQ-002 Parameter FIFO_DEPTH, default 4, sample FIFO entries; power of two, 2..16.
REQ-003 mck_i  in  1  sole clock; all logic on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-low.
REQ-005 s_valid_i  in  1  sample offered.
REQ-006 s_ready_o  out  1  FIFO can accept; transfer when s_valid_i & s_ready_o.
REQ-007 s_chan_i  in  1  0 = left/DAC A, 1 = right/DAC B.
REQ-008 s_data_i  in  16  signed two's-complement sample.
REQ-009 sclk_o  out  1  DAC82002 serial clock; idle high.
REQ-010 sync_o  out  1  frame select, active-low.
REQ-011 sdo_o  out  1  serial data, MSB first.
REQ-012 busy_o  out  1  high while FSM not in IDLE.
REQ-013 frame_done_o  out  1  one-cycle pulse at end of each frame.

Function
REQ-014 FIFO stores {chan, data}; s_ready_o = !full; push on handshake; no push when full, even if a pop occurs in the same cycle.
REQ-015 FIFO pointers wrap modulo FIFO_DEPTH; count distinguishes full from empty.
REQ-016 FSM states IDLE, SHIFT, GAP.
REQ-017 IDLE: if FIFO non-empty, pop one entry, load 24-bit frame {cmd, code}, go SHIFT; else stay.
REQ-018 cmd = 8'h08 for chan 0, 8'h09 for chan 1.
REQ-019 code per Configuration REQ-030.
REQ-020 SHIFT: sync_o low for exactly 48*CLK_DIV cycles; bit k (k = 0..23) takes 2*CLK_DIV cycles: sclk_o high for CLK_DIV cycles, then low for CLK_DIV cycles; sdo_o = frame[23-k] for the whole bit period, changing only when sclk_o rises.
REQ-021 Latency: handshake at edge N into an empty FIFO with FSM in IDLE -> pop at edge N+1 -> sync_o low, sclk_o high, sdo_o = frame[23] after edge N+2.
REQ-022 After the low phase of bit 23: sync_o 1, sclk_o 1, sdo_o 0, frame_done_o pulses 1 cycle, go GAP.
REQ-023 GAP: hold sync_o high for 2*CLK_DIV cycles, then IDLE; back-to-back frames separated by 2*CLK_DIV+1 cycles of sync_o high.
REQ-024 Bit counter 5 bits, divider counter 8 bits; neither wraps within a frame.
REQ-025 s_valid_i/s_data_i changes while s_ready_o low are ignored; the entry accepted is the one present at the handshake edge.

Reset
REQ-026 Asserting rst_i at any time, including mid-frame, forces immediately: sync_o 1, sclk_o 1, sdo_o 0, busy_o 0, frame_done_o 0, s_ready_o 0, FSM IDLE, FIFO empty, counters 0.
REQ-027 An interrupted frame is discarded, never resumed.
REQ-028 s_ready_o rises in the first cycle after rst_i deasserts.

Configuration
REQ-029 Macro DAC_SPI_TX_OFFSET_BIN_EN selects code conversion.
REQ-030 Defined: code = s_data_i with bit 15 inverted (offset binary for unipolar DAC). Undefined: code = s_data_i unchanged.

Structure
REQ-031 Package dac82002_pkg holds CMD_DAC_A (8'h08), CMD_DAC_B (8'h09), FRAME_W (24), SAMPLE_W (16) and the FSM state enum.
REQ-032 FIFO is sub-module sample_fifo (synchronous, same clock/reset, parameterised width/depth); FSM, divider and shifter stay in dac_spi_tx.

Verification
REQ-033 CLK_DIV=2, macro on: push chan0 16'h0000 -> sync_o low 96 cycles, sdo_o bits 24'h088000, one frame_done_o pulse.
REQ-034 Macro off: push chan1 16'h8001 -> frame 24'h098001; sync_o falls 2 cycles after handshake.
REQ-035 Push 5 samples back-to-back, FIFO_DEPTH=4 -> s_ready_o low once FIFO is full, all 5 frames emitted in order, sync_o high 5 cycles between frames.
REQ-036 Assert rst_i at bit 10 of a frame -> outputs to reset values same cycle, FIFO empty, no frame_done_o pulse.
REQ-037 CLK_DIV=1, push 16'h7FFF chan0, macro on -> frame 24'h08FFFF, sclk_o period 2 cycles, sdo_o stable across every sclk_o falling edge.
